// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel scan controller: scan states,
// parameter defaults and the bit order of the registered panel pin bundle.
package led_panel_pkg;

    localparam int COLS_DEFAULT           = 32;
    localparam int DISPLAY_CYCLES_DEFAULT = 256;

    // Dwell counter width: covers 2*COLS-1 (max 127) and DISPLAY_CYCLES-1 (max 65534).
    localparam int DWELL_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_BLANK,
        ST_ADDR,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_t;

    // Panel pins, MSB first: colour, shift clock, latch, blank, row address.
    typedef struct packed {
        logic red;
        logic green;
        logic blue;
        logic sclk;
        logic latch;
        logic blank;
        logic aclk;
        logic arst;
    } panel_pins_t;

    // Quiet panel: display blanked, every strobe and colour low.
    localparam panel_pins_t PINS_QUIET = '{
        red: 1'b0, green: 1'b0, blue: 1'b0, sclk: 1'b0,
        latch: 1'b0, blank: 1'b1, aclk: 1'b0, arst: 1'b0
    };

endpackage

// File: rtl/led_panel_dwell_counter.sv
// Reloadable down-counter timing the SHIFT and DISPLAY dwell periods.
// Loading value N gives N+1 cycles until zero is flagged; it parks at zero.
// count_next is exposed so the controller can register outputs aligned
// with the cycle they describe.
module led_panel_dwell_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] count_next,
    output logic         zero
);

    logic [W-1:0] count;

    // Reload on strobe, otherwise count down and stop at zero.
    always_comb begin
        // NOTE: every path assigns count_next, so no latch is inferred.
        if (load) begin
            count_next = load_value;
        end else if (count != '0) begin
            count_next = count - W'(1);
        end else begin
            count_next = count;
        end
    end

    assign zero = (count == '0);

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps every register update order-independent.
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/led_panel_scan_ctrl.sv
// HUB75-style LED panel scan controller: shifts one row of pixels, blanks,
// advances the row address, latches, then displays with PWM-style on-time.
// All outputs are registered from the next-state decode so they line up
// with the state they belong to.
module led_panel_scan_ctrl
    import led_panel_pkg::*;
#(
    parameter int COLS           = COLS_DEFAULT,
    parameter int DISPLAY_CYCLES = DISPLAY_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_in,
    input  logic [3:0]  rowmax_in,
    input  logic [15:0] bright_in,
    output logic        pix_req,
    output logic [5:0]  pix_col,
    output logic [3:0]  pix_row,
    input  logic [2:0]  pix_rgb,
    output logic        red_out,
    output logic        green_out,
    output logic        blue_out,
    output logic        sclk_out,
    output logic        latch_out,
    output logic        blank_out,
    output logic        aclk_out,
    output logic        arst_out,
    output logic        frame_start
);

    localparam logic [DWELL_W-1:0] SHIFT_LOAD   = DWELL_W'(2 * COLS - 1);
    localparam logic [DWELL_W-1:0] DISPLAY_LOAD = DWELL_W'(DISPLAY_CYCLES - 1);
    localparam logic [DWELL_W-1:0] LAST_COL     = DWELL_W'(COLS - 1);

    scan_state_t        state, state_next;
    logic [3:0]         row, row_next, rowmax_q;
    logic [15:0]        bright_q, bright_eff;
    logic               cnt_load, cnt_zero, frame_begin;
    logic [DWELL_W-1:0] cnt_load_value, cnt_next;

    panel_pins_t        pins_q, pins_next;
    logic               pix_req_next, frame_start_next;
    logic [5:0]         pix_col_next;
    logic [3:0]         pix_row_next;

    led_panel_dwell_counter #(.W(DWELL_W)) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .count_next (cnt_next),
        .zero       (cnt_zero)
    );

    // State register; rowmax is frozen per frame, brightness per row.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            row      <= '0;
            rowmax_q <= '0;
            bright_q <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
            if (frame_begin) begin
                rowmax_q <= rowmax_in;
            end
            if (state == ST_LATCH) begin
                bright_q <= bright_in;
            end
        end
    end

    // Next-state decode and dwell counter reloads.
    always_comb begin
        state_next     = state;
        row_next       = row;
        cnt_load       = 1'b0;
        cnt_load_value = SHIFT_LOAD;
        frame_begin    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable_in) begin
                    state_next  = ST_SHIFT;
                    row_next    = '0;
                    cnt_load    = 1'b1;
                    frame_begin = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_zero) begin
                    state_next = ST_BLANK;
                end
            end
            ST_BLANK: state_next = ST_ADDR;
            ST_ADDR:  state_next = ST_LATCH;
            ST_LATCH: begin
                state_next     = ST_DISPLAY;
                cnt_load       = 1'b1;
                cnt_load_value = DISPLAY_LOAD;
            end
            ST_DISPLAY: begin
                if (cnt_zero) begin
                    if (row < rowmax_q) begin
                        row_next   = row + 4'd1;
                        state_next = ST_SHIFT;
                        cnt_load   = 1'b1;
                    end else begin
                        row_next = '0;
                        if (enable_in) begin
                            state_next  = ST_SHIFT;
                            cnt_load    = 1'b1;
                            frame_begin = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // On the first DISPLAY cycle the brightness register is not loaded yet.
    assign bright_eff = (state == ST_LATCH) ? bright_in : bright_q;

    // Output decode for the coming cycle; odd count values are request phases.
    always_comb begin
        pins_next        = PINS_QUIET;
        pix_req_next     = 1'b0;
        pix_col_next     = '0;
        pix_row_next     = '0;
        frame_start_next = frame_begin;
        {pins_next.red, pins_next.green, pins_next.blue} =
            pix_req ? pix_rgb : {pins_q.red, pins_q.green, pins_q.blue};
        case (state_next)
            ST_IDLE: begin
                {pins_next.red, pins_next.green, pins_next.blue} = 3'b000;
            end
            ST_SHIFT: begin
                pix_req_next   = cnt_next[0];
                pins_next.sclk = ~cnt_next[0];
                pix_col_next   = 6'(LAST_COL - (cnt_next >> 1));
                pix_row_next   = row_next;
            end
            ST_ADDR: begin
                pins_next.arst = (row_next == '0);
                pins_next.aclk = (row_next != '0);
            end
            ST_LATCH: begin
                pins_next.latch = 1'b1;
            end
            ST_DISPLAY: begin
                pins_next.blank = !((DISPLAY_LOAD - cnt_next) < bright_eff);
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pins_q      <= PINS_QUIET;
            pix_req     <= 1'b0;
            pix_col     <= '0;
            pix_row     <= '0;
            frame_start <= 1'b0;
        end else begin
            pins_q      <= pins_next;
            pix_req     <= pix_req_next;
            pix_col     <= pix_col_next;
            pix_row     <= pix_row_next;
            frame_start <= frame_start_next;
        end
    end

    assign red_out   = pins_q.red;
    assign green_out = pins_q.green;
    assign blue_out  = pins_q.blue;
    assign sclk_out  = pins_q.sclk;
    assign latch_out = pins_q.latch;
    assign blank_out = pins_q.blank;
    assign aclk_out  = pins_q.aclk;
    assign arst_out  = pins_q.arst;

endmodule

// File: doc/led_panel_scan_ctrl.md
LED_PANEL_SCAN_CTRL -- requirements
Module: led_panel_scan_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 32: columns shifted per row; range 2..64.
REQ-002 SHALL have parameter DISPLAY_CYCLES, default 256: length of the DISPLAY state in clk cycles; range 2..65535.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable_in, input, 1 bit: scanning permitted; checked only at frame boundaries.
REQ-006 SHALL have port rowmax_in, input, 4 bits: index of the last row; rows = rowmax_in+1.
REQ-007 SHALL have port bright_in, input, 16 bits: on-time within DISPLAY, in cycles.
REQ-008 SHALL have port pix_req, output, 1 bit: pixel fetch strobe.
REQ-009 SHALL have port pix_col, output, 6 bits: column index of the fetch.
REQ-010 SHALL have port pix_row, output, 4 bits: row index of the fetch.
REQ-011 SHALL have port pix_rgb, input, 3 bits: {r,g,b} for pix_row/pix_col; combinationally valid in the same cycle as pix_req.
REQ-012 SHALL have ports red_out, green_out, blue_out, sclk_out, latch_out, blank_out, aclk_out, arst_out: outputs, 1 bit each, panel pins, all registered.
REQ-013 SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-014 SHALL implement the states IDLE, SHIFT, BLANK, ADDR, LATCH and DISPLAY.
REQ-015 SHALL, in IDLE, hold blank_out=1 and all other outputs at 0, and leave IDLE for SHIFT with row=0 on the cycle after enable_in=1 is sampled.
REQ-016 SHALL, on entering SHIFT for row 0, pulse frame_start for one cycle and capture rowmax_in into rowmax_q; rowmax_in changes mid-frame SHALL have no effect.
REQ-017 SHALL, in SHIFT, spend 2 cycles per column c = 0..COLS-1 in the order below.
REQ-018 SHALL, in the request phase of a column, drive pix_req=1, pix_col=c, pix_row=row and sclk_out=0, and register pix_rgb into red_out, green_out and blue_out at the end of that cycle.
REQ-019 SHALL, in the clock phase of a column, drive sclk_out=1 and pix_req=0 with the colour outputs unchanged; SHIFT therefore lasts 2*COLS cycles.
REQ-020 SHALL make pix_col and pix_row don't-care whenever pix_req=0.
REQ-021 SHALL, in BLANK (1 cycle), drive blank_out=1 with sclk_out=0.
REQ-022 SHALL, in ADDR (1 cycle), drive arst_out=1 if row==0, otherwise aclk_out=1, and never assert both.
REQ-023 SHALL, in LATCH (1 cycle), drive latch_out=1.
REQ-024 SHALL sample bright_in on entry to DISPLAY, then hold blank_out=0 for the first min(bright_in, DISPLAY_CYCLES) cycles and blank_out=1 for the rest.
REQ-025 SHALL, when the sampled bright_in is 0, keep blank_out=1 for the whole of DISPLAY.
REQ-026 SHALL hold blank_out=1 in every state other than the on-portion of DISPLAY.
REQ-027 SHALL, at the end of DISPLAY with row<rowmax_q, increment row and go to SHIFT.
REQ-028 SHALL, at the end of DISPLAY with row==rowmax_q, set row=0 and go to SHIFT if enable_in=1, else to IDLE.
REQ-029 SHALL produce a row period of 2*COLS+3+DISPLAY_CYCLES cycles (323 at the defaults).
REQ-030 SHALL treat rowmax_in=0 as a single-row frame: arst_out pulses every row and aclk_out never pulses.
REQ-031 SHALL hold aclk_out, arst_out, latch_out, pix_req, sclk_out and frame_start at 0 outside the cycles that define them.

Reset
REQ-032 SHALL, while reset=1, force state=IDLE, row=0, rowmax_q=0 and all counters to 0.
REQ-033 SHALL, while reset=1, drive blank_out=1 and every other output 0, with the values visible on the cycle after reset is sampled.
REQ-034 SHALL abort a frame when reset is asserted mid-frame, resume only via IDLE, and emit no partial latch, aclk or arst pulse.

Structure
REQ-035 SHALL take the state enum, the COLS/DISPLAY_CYCLES defaults and the panel pin bundle order from a shared package led_panel_pkg.
REQ-036 SHALL implement the reloadable down-counter that times SHIFT and DISPLAY as a single sub-module led_panel_dwell_counter (load value, load strobe, zero flag).

Verification
REQ-037 SHALL cover: reset held 3 cycles with enable_in=1 -> blank_out=1, other outputs 0 during reset; frame_start pulses 1 cycle after release.
REQ-038 SHALL cover: COLS=4, pix_rgb=col[2:0] -> 4 sclk_out rising edges, with red/green/blue equal to 0,1,2,3 at the respective rising edges, then BLANK, ADDR, LATCH in order.
REQ-039 SHALL cover: rowmax_in=2, 2 frames -> per frame exactly 1 arst_out and 2 aclk_out pulses, pix_row sequence 0,1,2, and frame_start period 3*(2*COLS+3+DISPLAY_CYCLES).
REQ-040 SHALL cover: bright_in 0, 100 and 300 with DISPLAY_CYCLES=256 -> blank_out low for 0, 100 and 256 cycles per DISPLAY respectively.
REQ-041 SHALL cover: enable_in dropped mid-frame -> the frame completes, then IDLE with blank_out=1 and no further pix_req.
REQ-042 SHALL cover: reset asserted during SHIFT of row 1 -> next cycle blank_out=1, sclk_out=0, latch_out=0, and the next frame restarts at row 0 with an arst_out pulse.
